// File: rtl/vga_frame_colour_gen_if.sv
// Video/keyboard bundle for vga_frame_colour_gen.
// master : keyboard side drives key_valid/key_code, observes the video outputs.
// slave  : the generator receives key_valid/key_code, drives sync, blanking,
//          coordinates, frame marker, colour channels and the applied mode.
interface vga_frame_colour_gen_if #(
  parameter int CNT_W   = 11,
  parameter int COLOR_W = 8
);
  logic               key_valid;
  logic [7:0]         key_code;
  logic               h_sync;
  logic               v_sync;
  logic               blank_n;
  logic               sync_n;
  logic               de;
  logic [CNT_W-1:0]   x;
  logic [CNT_W-1:0]   y;
  logic               frame_start;
  logic [COLOR_W-1:0] red;
  logic [COLOR_W-1:0] green;
  logic [COLOR_W-1:0] blue;
  logic [2:0]         mode;

  modport master (
    output key_valid, key_code,
    input  h_sync, v_sync, blank_n, sync_n, de, x, y, frame_start,
           red, green, blue, mode
  );

  modport slave (
    input  key_valid, key_code,
    output h_sync, v_sync, blank_n, sync_n, de, x, y, frame_start,
           red, green, blue, mode
  );
endinterface

// File: rtl/vga_frame_colour_gen.sv
// Parametrised VGA timing generator with a keyboard-selected colour source.
// Ports:
//   pixel_clk : pixel clock
//   reset     : asynchronous, active-low
//   bus       : slave side of vga_frame_colour_gen_if
//               in : key_valid (one-cycle strobe), key_code (scan code)
//               out: h_sync, v_sync, blank_n, sync_n (tied 0), de (= blank_n),
//                    x, y (0 outside active video), frame_start (pixel 0,0),
//                    red, green, blue, mode (currently applied mode)
// Every output is registered one cycle after the counter state it decodes,
// so sync, enable, coordinates and colour leave the block mutually aligned.
module vga_frame_colour_gen #(
  parameter int H_ACT   = 640,
  parameter int H_FP    = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BP    = 48,
  parameter int V_ACT   = 480,
  parameter int V_FP    = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BP    = 33,
  parameter bit HS_POL  = 1'b0,
  parameter bit VS_POL  = 1'b0,
  parameter int CNT_W   = 11,
  parameter int COLOR_W = 8
) (
  input logic                 pixel_clk,
  input logic                 reset,
  vga_frame_colour_gen_if.slave bus
);

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_ACT + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_ACT + V_FP + V_SYNC + V_BP - 1);
  localparam logic [CNT_W-1:0] H_ACT_C  = CNT_W'(H_ACT);
  localparam logic [CNT_W-1:0] V_ACT_C  = CNT_W'(V_ACT);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACT + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACT + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACT + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACT + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(H_ACT / 8 - 1);

  localparam logic [2:0] M_BLACK = 3'd0;
  localparam logic [2:0] M_RED   = 3'd1;
  localparam logic [2:0] M_GREEN = 3'd2;
  localparam logic [2:0] M_BLUE  = 3'd3;
  localparam logic [2:0] M_WHITE = 3'd4;
  localparam logic [2:0] M_BARS  = 3'd5;

  // Returns {recognised, mode}; unrecognised codes come back with bit 3 clear.
  function automatic logic [3:0] decode_key(input logic [7:0] code);
    case (code)
      8'h72:   return {1'b1, M_RED};
      8'h67:   return {1'b1, M_GREEN};
      8'h62:   return {1'b1, M_BLUE};
      8'h77:   return {1'b1, M_WHITE};
      8'h6B:   return {1'b1, M_BLACK};
      8'h70:   return {1'b1, M_BARS};
      default: return 4'b0000;
    endcase
  endfunction

  // Colour for an active pixel as {red, green, blue}. In BARS mode the bar
  // index bits map straight onto the three channels.
  function automatic logic [3*COLOR_W-1:0] pixel_colour(input logic [2:0] m,
                                                        input logic [2:0] idx);
    logic [COLOR_W-1:0] ones;
    logic [COLOR_W-1:0] zero;
    ones = '1;
    zero = '0;
    case (m)
      M_RED:   return {ones, zero, zero};
      M_GREEN: return {zero, ones, zero};
      M_BLUE:  return {zero, zero, ones};
      M_WHITE: return {ones, ones, ones};
      M_BARS:  return {{COLOR_W{idx[2]}}, {COLOR_W{idx[1]}}, {COLOR_W{idx[0]}}};
      default: return {zero, zero, zero};
    endcase
  endfunction

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic [CNT_W-1:0] bar_cnt;
  logic [2:0]       bar_idx;
  logic [2:0]       mode_q;
  logic [2:0]       pending_q;
  logic             line_end;
  logic             frame_end;
  logic [3:0]       key_dec;

  assign line_end  = (h_cnt == H_LAST);
  assign frame_end = line_end && (v_cnt == V_LAST);
  assign key_dec   = decode_key(bus.key_code);

  // ---- stage p0: counters, bar tracking, mode registers ----
  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      h_cnt     <= '0;
      v_cnt     <= '0;
      bar_cnt   <= '0;
      bar_idx   <= '0;
      mode_q    <= M_BLACK;
      pending_q <= M_BLACK;
    end else begin
      if (line_end) begin
        h_cnt   <= '0;
        v_cnt   <= (v_cnt == V_LAST) ? '0 : v_cnt + CNT_W'(1);
        bar_cnt <= '0;
        bar_idx <= '0;
      end else begin
        h_cnt <= h_cnt + CNT_W'(1);
        // Bar index steps every BAR_W pixels by a running count instead of
        // dividing h_cnt; pixels past the eighth bar stay in bar 7.
        if (bar_cnt == BAR_LAST) begin
          bar_cnt <= '0;
          if (bar_idx != 3'd7) bar_idx <= bar_idx + 3'd1;
        end else begin
          bar_cnt <= bar_cnt + CNT_W'(1);
        end
      end
      // Apply on the last pixel of the frame so the change shows from (0,0).
      // A key arriving on that same cycle only lands in pending.
      if (frame_end) mode_q <= pending_q;
      if (bus.key_valid && key_dec[3]) pending_q <= key_dec[2:0];
    end
  end

  logic                   vld_p0;
  logic [3*COLOR_W-1:0]   colour_p0;

  assign vld_p0    = (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
  assign colour_p0 = vld_p0 ? pixel_colour(mode_q, bar_idx) : '0;

  logic                 h_sync_p1;
  logic                 v_sync_p1;
  logic                 vld_p1;
  logic [CNT_W-1:0]     x_p1;
  logic [CNT_W-1:0]     y_p1;
  logic                 frame_start_p1;
  logic [3*COLOR_W-1:0] colour_p1;

  // ---- stage p1: registered video outputs ----
  always_ff @(posedge pixel_clk or negedge reset) begin
    if (!reset) begin
      h_sync_p1      <= ~HS_POL;
      v_sync_p1      <= ~VS_POL;
      vld_p1         <= 1'b0;
      x_p1           <= '0;
      y_p1           <= '0;
      frame_start_p1 <= 1'b0;
      colour_p1      <= '0;
    end else begin
      h_sync_p1      <= (h_cnt >= HS_START && h_cnt < HS_END) ? HS_POL : ~HS_POL;
      v_sync_p1      <= (v_cnt >= VS_START && v_cnt < VS_END) ? VS_POL : ~VS_POL;
      vld_p1         <= vld_p0;
      x_p1           <= vld_p0 ? h_cnt : '0;
      y_p1           <= vld_p0 ? v_cnt : '0;
      frame_start_p1 <= (h_cnt == '0) && (v_cnt == '0);
      colour_p1      <= colour_p0;
    end
  end

  assign bus.h_sync      = h_sync_p1;
  assign bus.v_sync      = v_sync_p1;
  assign bus.blank_n     = vld_p1;
  assign bus.de          = vld_p1;
  assign bus.sync_n      = 1'b0;
  assign bus.x           = x_p1;
  assign bus.y           = y_p1;
  assign bus.frame_start = frame_start_p1;
  assign bus.red         = colour_p1[3*COLOR_W-1:2*COLOR_W];
  assign bus.green       = colour_p1[2*COLOR_W-1:COLOR_W];
  assign bus.blue        = colour_p1[COLOR_W-1:0];
  assign bus.mode        = mode_q;

endmodule
